// File: rtl/cla_pkg.sv
// Shared types and constants for the pipelined carry-lookahead adder/subtractor.
// Holds the stage-payload struct and the saturation limit functions.
// The struct is sized for the widest supported operand; unused upper bits are constant.
package cla_pkg;

    localparam int CLA_MAX_W = 64;

    // One pipeline stage's payload: control, conditioned operands, sum built so far.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 sub;
        logic                 sat;
        logic [CLA_MAX_W-1:0] a;
        logic [CLA_MAX_W-1:0] b;
        logic [CLA_MAX_W-1:0] sum;
    } cla_stage_t;

    // Largest positive two's-complement value of the given width (0x7F..F).
    function automatic logic [CLA_MAX_W-1:0] sat_pos(input int width);
        logic [CLA_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < CLA_MAX_W; i++) begin
            if (i < width - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Most negative two's-complement value of the given width (0x80..0).
    function automatic logic [CLA_MAX_W-1:0] sat_neg(input int width);
        logic [CLA_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < CLA_MAX_W; i++) begin
            if (i == width - 1) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/cla_block.sv
// One BLOCK_SIZE-bit carry-lookahead slice: P/G, flat lookahead carries, sum bits.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline stage register holds the state.
module cla_block #(
    parameter int BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] a,
    input  logic [BLOCK_SIZE-1:0] b,
    input  logic                  cin,
    output logic [BLOCK_SIZE-1:0] sum,
    output logic                  cout
);
    logic [BLOCK_SIZE-1:0] p;
    logic [BLOCK_SIZE-1:0] g;
    logic [BLOCK_SIZE:0]   c;
    logic                  term;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is an independent sum of products over G, P and cin (no ripple chain).
    always_comb begin
        c    = '0;
        term = 1'b0;
        for (int i = 0; i <= BLOCK_SIZE; i++) begin
            term = cin;
            for (int m = 0; m < i; m++) term = term & p[m];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                c[i] = c[i] | term;
            end
        end
    end

    assign sum  = p ^ c[BLOCK_SIZE-1:0];
    assign cout = c[BLOCK_SIZE];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA add/sub; one lookahead block per stage; optional saturation via CLA_SATURATE_EN.
// Latency WIDTH/BLOCK_SIZE cycles from accept to out_valid; one op per cycle when flowing.
// Backpressure: all stages hold while out_valid & ~out_ready; in_ready = ~out_valid | out_ready.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             OF
);
    localparam int NSTAGE = (BLOCK_SIZE >= 1) ? WIDTH / BLOCK_SIZE : 1;
    localparam int REM    = (BLOCK_SIZE >= 1) ? WIDTH % BLOCK_SIZE : 1;

    if (BLOCK_SIZE < 1 || REM != 0 || WIDTH > CLA_MAX_W) begin : g_bad_cfg
        $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK_SIZE >= 1 and <= CLA_MAX_W");
    end

    cla_stage_t stg_q [NSTAGE];
    cla_stage_t fin;
    logic       adv;

    assign fin = stg_q[NSTAGE-1];
    assign adv = ~fin.valid | out_ready;
    // Reset empties the pipe, so input is never refused while rst is high.
    assign in_ready = adv | rst;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        cla_stage_t            src;
        cla_stage_t            nxt;
        logic [BLOCK_SIZE-1:0] blk_sum;
        logic                  blk_cout;

        if (k == 0) begin : g_head
            // Stage 0 takes live operands; B is inverted and Sub injected as carry-in for subtract.
            always_comb begin
                src       = '0;
                src.valid = in_valid;
                src.carry = Sub;
                src.sub   = Sub;
`ifdef CLA_SATURATE_EN
                src.sat   = Sat;
`endif
                src.a[WIDTH-1:0] = A;
                src.b[WIDTH-1:0] = B ^ {WIDTH{Sub}};
            end
        end else begin : g_body
            assign src = stg_q[k-1];
        end

        cla_block #(
            .BLOCK_SIZE(BLOCK_SIZE)
        ) u_blk (
            .a   (src.a[k*BLOCK_SIZE +: BLOCK_SIZE]),
            .b   (src.b[k*BLOCK_SIZE +: BLOCK_SIZE]),
            .cin (src.carry),
            .sum (blk_sum),
            .cout(blk_cout)
        );

        // Drop this block's sum slice into the payload and replace the carry with its carry-out.
        always_comb begin
            nxt = src;
            nxt.sum[k*BLOCK_SIZE +: BLOCK_SIZE] = blk_sum;
            nxt.carry = blk_cout;
        end

        // Stage register: cleared on reset, advances in lockstep with every other stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                stg_q[k] <= '0;
            end else if (adv) begin
                stg_q[k] <= nxt;
            end
        end
    end

    logic             c_msb;
    logic [WIDTH-1:0] wrapped;

    // Carry into the MSB recovered from the MSB's own sum equation.
    assign c_msb     = fin.a[WIDTH-1] ^ fin.b[WIDTH-1] ^ fin.sum[WIDTH-1];
    assign wrapped   = fin.sum[WIDTH-1:0];
    assign out_valid = fin.valid;
    assign Cout      = fin.carry;
    assign OF        = c_msb ^ fin.carry;

`ifdef CLA_SATURATE_EN
    localparam logic [WIDTH-1:0] POS_LIM = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] NEG_LIM = WIDTH'(sat_neg(WIDTH));

    // On overflow the wrapped sign is inverted, so a negative-looking result means true positive.
    always_comb begin
        Sum = wrapped;
        if (fin.sat && OF) begin
            Sum = wrapped[WIDTH-1] ? POS_LIM : NEG_LIM;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = Sat;
    assign Sum        = wrapped;
`endif

    logic unused_fin;
    assign unused_fin = ^fin;

endmodule

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4: bits per lookahead block; one pipeline stage per block.
REQ-003 SHALL have these ports (name, direction, width, meaning), clock and reset first, one per line:
  clk  input  1  sole clock; all state updates on rising edge.
  rst  input  1  synchronous, active-high reset.
  in_valid  input  1  A/B/Sub/Sat present this cycle.
  in_ready  output  1  pipeline accepts input this cycle.
  A  input  WIDTH  operand A, two's complement.
  B  input  WIDTH  operand B, two's complement.
  Sub  input  1  0 = A+B, 1 = A-B.
  Sat  input  1  per-operation saturate request; ignored unless CLA_SATURATE_EN is defined.
  out_valid  output  1  result valid.
  out_ready  input  1  consumer accepts result.
  Sum  output  WIDTH  result.
  Cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
  OF  output  1  signed overflow.

Function
REQ-004 SHALL reject elaboration unless WIDTH is a multiple of BLOCK_SIZE and BLOCK_SIZE >= 1; NSTAGE = WIDTH/BLOCK_SIZE.
REQ-005 SHALL compute B' = B XOR {WIDTH{Sub}} with Sub as the carry-in of block 0.
REQ-006 SHALL, in stage k (0..NSTAGE-1), compute per-bit P = A^B' and G = A&B', then the block sum bits and the block carry-out by full lookahead over the block (no ripple inside a block).
REQ-007 SHALL register each block's carry-out and pass it to stage k+1 as carry-in; upper operand slices SHALL be delayed alongside it, and completed lower sum slices SHALL travel with the operation.
REQ-008 SHALL have latency exactly NSTAGE cycles from input accept (in_valid & in_ready) to out_valid.
REQ-009 SHALL accept one operation per cycle when not stalled; throughput 1.
REQ-010 SHALL advance all stages together when adv = ~out_valid | out_ready; in_ready = adv; when adv = 0, all stage registers hold.
REQ-011 SHALL insert a bubble (stage valid 0) when adv = 1 and in_valid = 0.
REQ-012 SHALL hold Sum/Cout/OF stable while out_valid = 1 and out_ready = 0.
REQ-013 SHALL set Cout = carry-out of the MSB block and OF = carry into MSB XOR carry out of MSB.
REQ-014 SHALL produce results independent of neighbouring operations, including back-to-back operations with different Sub.

Reset
REQ-015 SHALL, on rst = 1 at a clock edge, clear every stage valid bit; out_valid = 0, Sum = 0, Cout = 0, OF = 0 on the following cycle.
REQ-016 SHALL discard all in-flight operations on reset mid-operation; no partial result is ever emitted.
REQ-017 SHALL drive in_ready = 1 during and after reset (pipeline empty).

Configuration
REQ-018 SHALL, with CLA_SATURATE_EN defined, clamp the final-stage result when Sat = 1 and OF = 1: Sum = 0x7F..F if the true result is positive, 0x80..0 if negative; OF and Cout still report the unclamped values. Sat SHALL travel through the pipeline with its operation.
REQ-019 SHALL, without CLA_SATURATE_EN, ignore Sat and always emit the wrapped result; no Sat storage SHALL be synthesised.

Structure
REQ-020 SHALL place in shared package cla_pkg: the stage-payload struct typedef (valid, carry, Sub, Sat, operand slices, sum slices) and the saturation constant functions.
REQ-021 SHALL instantiate one sub-module cla_block (BLOCK_SIZE-bit P/G, lookahead carry, sum) per stage, configured through parameter.

Verification (WIDTH=8, BLOCK_SIZE=4 unless noted)
REQ-022 SHALL cover: A=0x7F, B=0x01, Sub=0 -> after 2 cycles Sum=0x80, Cout=0, OF=1.
REQ-023 SHALL cover: A=0x05, B=0x03, Sub=1 -> Sum=0x02, Cout=1, OF=0; A=0x80, B=0x01, Sub=1 -> Sum=0x7F, Cout=1, OF=1.
REQ-024 SHALL cover: 3 back-to-back ops with out_ready=0 for 4 cycles after the first result -> in_ready=0 while stalled, results held, delivered in order with no loss or duplication.
REQ-025 SHALL cover: rst asserted one cycle after accepting 2 ops -> out_valid stays 0, no result emitted, in_ready=1.
REQ-026 SHALL cover, with CLA_SATURATE_EN: A=0x7F, B=0x01, Sub=0, Sat=1 -> Sum=0x7F, OF=1; A=0x80, B=0x01, Sub=1, Sat=1 -> Sum=0x80, OF=1.
REQ-027 SHALL cover: WIDTH=32, BLOCK_SIZE=8, 10k random ops with random stalls -> every result matches a reference model, latency exactly 4 cycles.
